md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the pipelined MIPS core; owns the HI/LO registers.
- Executes mult/multu/div/divu over a fixed multi-cycle latency, and mthi/mtlo/mfhi/mflo.
- Its busy output, together with the E-stage start flag, feeds the hazard control unit. The hazard unit stalls any D-stage HI/LO access while this unit is starting or busy.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- mdstartE  input  1  E-stage instruction is mult/multu/div/divu.
- hlwriteE  input  1  E-stage instruction is mthi/mtlo.
- mdOpE  input  3  operation code (md_pkg encoding).
- srcAE  input  WIDTH  rs operand, after forwarding.
- srcBE  input  WIDTH  rt operand, after forwarding.
- busyE  output  1  operation in progress.
- hlOutE  output  WIDTH  mfhi/mflo read data.

Behaviour:
- Reset (async):
  - HI=0, LO=0, busyE=0, counter=0, pending result registers=0.
  - A reset asserted mid-operation aborts it; HI/LO stay 0 and no late write occurs.
- Start:
  - If mdstartE=1 and busyE=0 at edge t: latch the full 64-bit result into pending {pHI,pLO}, load counter with MULT_CYCLES or DIV_CYCLES, and set busyE=1 from t.
  - busyE stays high for exactly N cycles, where N is the loaded cycle count.
  - On the edge that ends the last busy cycle: HI<=pHI, LO<=pLO, busyE<=0. The new HI/LO is readable in the cycle busyE first reads 0.
- mdstartE while busyE=1: ignored; no state change. The hazard unit prevents this case; the unit tolerates it anyway.
- Arithmetic:
  - mult: signed 32x32 to 64; HI=upper word, LO=lower word.
  - multu: unsigned 32x32 to 64; same HI/LO split.
  - div: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - Divide by zero: full busy period runs; HI/LO unchanged at completion.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo:
  - If hlwriteE=1 and busyE=0: HI or LO <= srcAE at the edge.
  - Ignored while busyE=1.
  - If mdstartE and hlwriteE are both 1 in one cycle: mdstartE wins; treated as illegal.
- mfhi/mflo: hlOutE is combinational HI or LO per mdOpE; 0 for any other op.
- No pipeline flush input; an issued operation always completes unless reset.

Decomposition:
- md_pkg: op encodings MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MFHI=4, MD_MFLO=5, MD_MTHI=6, MD_MTLO=7; default cycle counts.
- One natural sub-module: md_calc, a combinational 64-bit result generator covering signed/unsigned multiply, divide and the divide-by-zero rule. md_unit holds the counter, busy flag and HI/LO.

Test Plan:
- Reset mid-op: reset while busyE=1 -> busyE=0 immediately; HI=LO=0; no update after reset release.
- mult -3 x 7: busyE high for 5 cycles -> then HI=0xFFFFFFFF, LO=0xFFFFFFEB; mflo reads 0xFFFFFFEB.
- divu 100/7: busyE high for 10 cycles -> LO=14, HI=2; HI/LO unchanged during busy.
- div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div x/0 -> busy for 10 cycles; HI/LO hold prior values.
- Sequencing:
  - mthi 0x1234 -> HI=0x1234 next cycle.
  - mtlo issued during a busy mult -> ignored.
  - mdstartE pulsed during busy -> counter not reloaded; busyE falls on schedule.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MFHI  = 3'd4,
        MD_MFLO  = 3'd5,
        MD_MTHI  = 3'd6,
        MD_MTLO  = 3'd7
    } mdOp_t;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    function automatic logic isDivOp(input mdOp_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic isSignedOp(input mdOp_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit HI/LO result generator for mult/multu/div/divu.
module md_calc
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  mdOp_t                op,
    input  logic [WIDTH-1:0]     srcA,
    input  logic [WIDTH-1:0]     srcB,
    output logic [2*WIDTH-1:0]   result,
    output logic                 resultValid
);

    logic                     extSign;
    logic signed [WIDTH:0]    extA;
    logic signed [WIDTH:0]    extB;
    logic signed [WIDTH:0]    divisor;
    logic signed [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]         quotient;
    logic [WIDTH-1:0]         remainder;

    // Operands are widened by one bit (sign or zero) so a single signed
    // multiplier/divider serves both flavours; this also makes
    // 0x80000000 / -1 produce 0x80000000 without overflow.
    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    always_comb begin
        extSign     = isSignedOp(op);
        extA        = {extSign & srcA[WIDTH-1], srcA};
        extB        = {extSign & srcB[WIDTH-1], srcB};
        divisor     = (srcB == '0) ? (WIDTH+1)'(1) : extB;
        product     = extA * extB;
        quotient    = WIDTH'(extA / divisor);
        remainder   = WIDTH'(extA % divisor);
        result      = product;
        resultValid = 1'b1;
        if (isDivOp(op)) begin
            result      = {remainder, quotient};
            resultValid = (srcB != '0);
        end
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: owns HI/LO and a fixed-latency busy window.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mdstartE,
    input  logic             hlwriteE,
    input  logic [2:0]       mdOpE,
    input  logic [WIDTH-1:0] srcAE,
    input  logic [WIDTH-1:0] srcBE,
    output logic             busyE,
    output logic [WIDTH-1:0] hlOutE
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    mdOp_t              op;
    logic [WIDTH-1:0]   hiReg, loReg, pHi, pLo;
    logic               pWrite;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] calcResult;
    logic               calcValid;

    assign op = mdOp_t'(mdOpE);

    md_calc #(.WIDTH(WIDTH)) calc (
        .op         (op),
        .srcA       (srcAE),
        .srcB       (srcBE),
        .result     (calcResult),
        .resultValid(calcValid)
    );

    // Result is captured at start; HI/LO commit on the edge ending the last
    // busy cycle. A divide by zero clears pWrite so HI/LO keep their values.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hiReg  <= '0;
            loReg  <= '0;
            pHi    <= '0;
            pLo    <= '0;
            pWrite <= 1'b0;
            count  <= '0;
            busyE  <= 1'b0;
        end else if (busyE) begin
            if (count == CW'(1)) begin
                busyE <= 1'b0;
                count <= '0;
                if (pWrite) begin
                    hiReg <= pHi;
                    loReg <= pLo;
                end
            end else begin
                count <= count - CW'(1);
            end
        end else if (mdstartE) begin
            {pHi, pLo} <= calcResult;
            pWrite     <= calcValid;
            count      <= isDivOp(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            busyE      <= 1'b1;
        end else if (hlwriteE) begin
            if (op == MD_MTHI) hiReg <= srcAE;
            if (op == MD_MTLO) loReg <= srcAE;
        end
    end

    always_comb begin
        hlOutE = '0;
        case (op)
            MD_MFHI: hlOutE = hiReg;
            MD_MFLO: hlOutE = loReg;
            default: hlOutE = '0;
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed, table-driven bench for md_unit with hand-computed HI/LO results.
module tb_md_unit;
    import md_pkg::*;

    localparam int BOUND = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic        mdstartE, hlwriteE;
    logic [2:0]  mdOpE;
    logic [31:0] srcAE, srcBE;
    logic        busyE;
    logic [31:0] hlOutE;

    int nCompared   = 0;
    int nMismatched = 0;
    logic [31:0] mHi, mLo;

    md_unit dut (
        .clk     (clk),
        .reset   (reset),
        .mdstartE(mdstartE),
        .hlwriteE(hlwriteE),
        .mdOpE   (mdOpE),
        .srcAE   (srcAE),
        .srcBE   (srcBE),
        .busyE   (busyE),
        .hlOutE  (hlOutE)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a, b, expHi, expLo;
        int          cycles;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called in the low half of the clock; reads HI then LO through the mf port.
    task automatic readHl(output logic [31:0] hi, output logic [31:0] lo);
        mdOpE = MD_MFHI; #1 hi = hlOutE;
        mdOpE = MD_MFLO; #1 lo = hlOutE;
    endtask

    task automatic startOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mdstartE = 1'b1; mdOpE = op; srcAE = a; srcBE = b;
        @(negedge clk);
        mdstartE = 1'b0; srcAE = '0; srcBE = '0;
    endtask

    // Counts busy cycles from the current negedge; HI/LO must hold meanwhile.
    task automatic countBusy(input string name, output int n);
        logic [31:0] hi, lo;
        n = 0;
        while (busyE && n < BOUND) begin
            readHl(hi, lo);
            check({name, " hold hi"}, hi, mHi);
            check({name, " hold lo"}, lo, mLo);
            n++;
            @(negedge clk);
        end
        if (n >= BOUND) check({name, " busy timeout"}, 32'(n), 32'(0));
    endtask

    initial begin
        logic [31:0] hi, lo;
        int n;

        vecs[0]  = '{"mult -3x7",        MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 5};
        vecs[1]  = '{"multu ffffffffx2", MD_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{"mult min*min",     MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[3]  = '{"mult -1x-1",       MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
        vecs[4]  = '{"multu max*max",    MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[5]  = '{"divu 100/7",       MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10};
        vecs[6]  = '{"div -7/2",         MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[7]  = '{"div 7/-2",         MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[8]  = '{"div min/-1",       MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[9]  = '{"divu max/16",      MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
        vecs[10] = '{"div 5/0",          MD_DIV,   32'd5,        32'd0,        32'h0000000F, 32'h0FFFFFFF, 10};

        reset = 1'b1; mdstartE = 1'b0; hlwriteE = 1'b0;
        mdOpE = MD_MFHI; srcAE = '0; srcBE = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busyE), 32'd0);
        readHl(hi, lo);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        reset = 1'b0;
        mHi = '0; mLo = '0;

        // mthi / mtlo
        @(negedge clk);
        hlwriteE = 1'b1; mdOpE = MD_MTHI; srcAE = 32'h1234;
        @(negedge clk);
        hlwriteE = 1'b0; srcAE = '0;
        readHl(hi, lo);
        check("mthi hi", hi, 32'h1234);
        check("mthi lo untouched", lo, 32'd0);
        hlwriteE = 1'b1; mdOpE = MD_MTLO; srcAE = 32'h5678;
        @(negedge clk);
        hlwriteE = 1'b0; srcAE = '0;
        readHl(hi, lo);
        check("mtlo lo", lo, 32'h5678);
        mHi = 32'h1234; mLo = 32'h5678;

        mdOpE = MD_MULT; #1;
        check("non-mf op reads 0", hlOutE, 32'd0);

        foreach (vecs[i]) begin
            startOp(vecs[i].op, vecs[i].a, vecs[i].b);
            countBusy(vecs[i].name, n);
            check({vecs[i].name, " busy cycles"}, 32'(n), 32'(vecs[i].cycles));
            readHl(hi, lo);
            check({vecs[i].name, " hi"}, hi, vecs[i].expHi);
            check({vecs[i].name, " lo"}, lo, vecs[i].expLo);
            mHi = vecs[i].expHi; mLo = vecs[i].expLo;
        end

        // divu by zero must also leave HI/LO intact
        startOp(MD_DIVU, 32'h80000000, 32'd0);
        countBusy("divu x/0", n);
        check("divu x/0 busy cycles", 32'(n), 32'd10);
        readHl(hi, lo);
        check("divu x/0 hi", hi, mHi);
        check("divu x/0 lo", lo, mLo);

        // mtlo attempted during a busy mult is ignored
        startOp(MD_MULT, 32'd2, 32'd3);
        check("mtlo-busy busy", 32'(busyE), 32'd1);
        hlwriteE = 1'b1; mdOpE = MD_MTLO; srcAE = 32'hDEAD;
        @(negedge clk);
        hlwriteE = 1'b0; srcAE = '0;
        countBusy("mtlo-busy", n);
        check("mtlo-busy cycles", 32'(n + 1), 32'd5);
        readHl(hi, lo);
        check("mtlo-busy hi", hi, 32'd0);
        check("mtlo-busy lo", lo, 32'd6);
        mHi = 32'd0; mLo = 32'd6;

        // mdstartE pulsed mid-operation must not reload the counter
        startOp(MD_DIVU, 32'd100, 32'd7);
        n = 0;
        while (busyE && n < BOUND) begin
            if (n == 3) begin
                mdstartE = 1'b1; mdOpE = MD_MULT; srcAE = 32'd9; srcBE = 32'd9;
                @(negedge clk);
                mdstartE = 1'b0; srcAE = '0; srcBE = '0;
            end else begin
                @(negedge clk);
            end
            n++;
        end
        if (n >= BOUND) check("restart busy timeout", 32'(n), 32'd0);
        check("restart busy cycles", 32'(n), 32'd10);
        readHl(hi, lo);
        check("restart hi", hi, 32'd2);
        check("restart lo", lo, 32'd14);

        // reset in the middle of a mult aborts it with no late write
        startOp(MD_MULT, 32'd1000, 32'd1000);
        @(negedge clk);
        reset = 1'b1; #1;
        check("midreset busy", 32'(busyE), 32'd0);
        readHl(hi, lo);
        check("midreset hi", hi, 32'd0);
        check("midreset lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("post-reset busy", 32'(busyE), 32'd0);
        readHl(hi, lo);
        check("post-reset hi", hi, 32'd0);
        check("post-reset lo", lo, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
